issue_arbiter_gen: RTL and testbench
====================================

ISSUE_ARBITER_GEN -- requirements
Module: issue_arbiter_gen

Interface
REQ-001 SHALL have parameter NUM_WF, default 40, number of wavefront slots.
REQ-002 SHALL have parameter WF_ID_W, default 6, wavefront id width; NUM_WF <= 2**WF_ID_W.
REQ-003 SHALL have parameters NUM_SIMD and NUM_SIMF, default 4 each, vector unit counts, each 1..8.
REQ-004 SHALL have parameter STARVE_LIMIT, default 8, starvation threshold in cycles, 1..15.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 salu_ready_to_issue, simd_ready_to_issue, simf_ready_to_issue, lsu_ready_to_issue  input  NUM_WF each  per-class wavefront ready vectors.
REQ-008 simd_alu_ready  input  NUM_SIMD, simf_alu_ready  input  NUM_SIMF, salu_alu_ready  input  1, lsu_ready  input  1  unit free flags.
REQ-009 simd_alu_select  output  NUM_SIMD, simf_alu_select  output  NUM_SIMF, salu_alu_select  output  1, lsu_lsu_select  output  1  one-hot unit selects.
REQ-010 issued_wfid, alu_wfid, lsu_wfid  output  WF_ID_W  issued wavefront id; all three equal.
REQ-011 issued_valid, alu_valid, lsu_valid  output  1  issue strobes.

Function
REQ-012 SHALL register all ready inputs (stage 1) and drive all selects, issued_wfid and issued_valid from flops (stage 2); input-to-output latency two rising edges.
REQ-013 SHALL mask each stage-1 wavefront vector with ~(current-cycle candidate | last-cycle issued) so no wavefront issues on consecutive cycles.
REQ-014 SHALL mask each stage-1 unit ready with ~(its registered select | its current select).
REQ-015 SHALL run one round-robin search per class: first set bit at or after pointer, wrapping NUM_WF-1 to 0; every class pointer loads (issued id + 1) mod NUM_WF on each issue.
REQ-016 Class eligible when its search finds a wavefront and a unit is free (SIMD/SIMF: any masked unit ready).
REQ-017 At most one issue per cycle; class priority rotates SALU(0), SIMD(1), SIMF(2), LSU(3) starting at class pointer; class pointer advances to (issued class + 1) mod 4.
REQ-018 SIMD/SIMF issue SHALL assert select of the lowest-index free unit only.
REQ-019 No eligible class: all selects 0, issued_valid 0, pointers unchanged; issued_wfid holds previous value.
REQ-020 alu_valid = OR of simd, simf, salu selects; lsu_valid = lsu_lsu_select.
REQ-021 Same wavefront ready in several classes: only the winning class issues it that cycle.

Reset
REQ-022 On rst low, immediately: all flops 0, all outputs 0, wavefront pointers 0, class pointer 0, starvation counters 0.
REQ-023 Reset mid-operation SHALL discard pending candidates; first issue possible two edges after rst deasserts.

Configuration
REQ-024 Macro ISSUE_STARVATION_GUARD_EN defined: per-class 4-bit saturating counter increments each cycle the class is eligible but not issued, clears when it issues; class at or above STARVE_LIMIT overrides rotation (lowest class index among starved wins).
REQ-025 Macro undefined: no counters, pure rotation per REQ-017; STARVE_LIMIT ignored.

Structure
REQ-026 Package issue_arb_pkg SHALL hold class encodings (CLS_SALU..CLS_LSU), class count 4, and parameter defaults.
REQ-027 Sub-module rr_arbiter (parametrised NUM_WF/WF_ID_W: vector, pointer -> valid, id) SHALL be instantiated four times.

Verification
REQ-028 salu_ready_to_issue bit 5, salu_alu_ready 1, rest 0 -> after two edges salu_alu_select 1, issued_wfid 5, alu_valid 1; next cycle no reissue of 5.
REQ-029 simd_ready bits 3 and 39, all 4 SIMD free, pointer 0 -> issues 3 (simd_alu_select 0001), then 39 (0010), then wraps to 3.
REQ-030 All four classes ready on distinct wfs 1,2,3,4, all units free -> issue order SALU, SIMD, SIMF, LSU, one per cycle.
REQ-031 Wf 7 ready in SALU and LSU simultaneously -> exactly one issue of 7, never two consecutive cycles.
REQ-032 With ISSUE_STARVATION_GUARD_EN, STARVE_LIMIT 2, LSU eligible while other classes continually win -> LSU issues within 3 cycles of first eligibility.
REQ-033 rst low while candidates pending -> all outputs 0 asynchronously; after release, first issue_valid exactly two edges later.

Source files
------------

// File: rtl/issue_arb_pkg.sv
// -----------------------------------------------------------------------------
// issue_arb_pkg
// Shared definitions for the wavefront issue arbiter:
//   - cls_e        : issue class encodings (SALU, SIMD, SIMF, LSU)
//   - NUM_CLS      : number of issue classes
//   - DEF_*        : parameter defaults used by issue_arbiter_gen / rr_arbiter
//   - STARVE_CNT_W : width of the optional per-class starvation counters
//   - next_cls()   : rotating class successor (wraps LSU -> SALU)
// -----------------------------------------------------------------------------
package issue_arb_pkg;

    typedef enum logic [1:0] {
        CLS_SALU = 2'd0,
        CLS_SIMD = 2'd1,
        CLS_SIMF = 2'd2,
        CLS_LSU  = 2'd3
    } cls_e;

    localparam int NUM_CLS          = 4;
    localparam int DEF_NUM_WF       = 40;
    localparam int DEF_WF_ID_W      = 6;
    localparam int DEF_NUM_SIMD     = 4;
    localparam int DEF_NUM_SIMF     = 4;
    localparam int DEF_STARVE_LIMIT = 8;
    localparam int STARVE_CNT_W     = 4;

    // Four classes in a 2-bit encoding, so the increment wraps naturally.
    function automatic cls_e next_cls(input cls_e c);
        return cls_e'(c + 2'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin search over a wavefront vector: finds the first set bit at or
// after the pointer, wrapping from NUM_WF-1 back to 0.
// Ports:
//   vec_i   [NUM_WF]  candidate wavefront vector
//   ptr_i   [WF_ID_W] search start position (always < NUM_WF)
//   valid_o           a set bit was found
//   id_o    [WF_ID_W] index of the found bit (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter
    import issue_arb_pkg::*;
#(
    parameter int NUM_WF  = DEF_NUM_WF,
    parameter int WF_ID_W = DEF_WF_ID_W
) (
    input  logic [NUM_WF-1:0]  vec_i,
    input  logic [WF_ID_W-1:0] ptr_i,
    output logic               valid_o,
    output logic [WF_ID_W-1:0] id_o
);

    logic [NUM_WF-1:0]  rot;
    logic [WF_ID_W:0]   sum;

    // Rotate so that bit 0 of rot corresponds to position ptr_i.
    assign rot = NUM_WF'({vec_i, vec_i} >> ptr_i);

    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        valid_o = 1'b0;
        sum     = '0;
        // Walk downward so the last hit (lowest offset) wins.
        for (int k = NUM_WF - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid_o = 1'b1;
                sum     = {1'b0, ptr_i} + (WF_ID_W + 1)'(k);
            end
        end
        if (sum >= (WF_ID_W + 1)'(NUM_WF)) begin
            id_o = WF_ID_W'(sum - (WF_ID_W + 1)'(NUM_WF));
        end else begin
            id_o = sum[WF_ID_W-1:0];
        end
    end

endmodule

// File: rtl/issue_arbiter_gen.sv
// -----------------------------------------------------------------------------
// issue_arbiter_gen
// Two-stage wavefront issue arbiter. Stage 1 registers the per-class ready
// vectors and unit-free flags; stage 2 picks at most one (class, wavefront,
// unit) per cycle and drives the selects / issued id from flops.
// Optional feature: define ISSUE_STARVATION_GUARD_EN to add per-class
// starvation counters that override the rotating class priority.
// Ports:
//   clk, rst (async, active-low)
//   {salu,simd,simf,lsu}_ready_to_issue [NUM_WF]  per-class ready wavefronts
//   simd_alu_ready [NUM_SIMD], simf_alu_ready [NUM_SIMF],
//   salu_alu_ready, lsu_ready                     unit free flags
//   simd_alu_select, simf_alu_select, salu_alu_select, lsu_lsu_select
//                                                 one-hot unit selects
//   issued_wfid / alu_wfid / lsu_wfid [WF_ID_W]   issued wavefront id
//   issued_valid, alu_valid, lsu_valid            issue strobes
// -----------------------------------------------------------------------------
module issue_arbiter_gen
    import issue_arb_pkg::*;
#(
    parameter int NUM_WF       = DEF_NUM_WF,
    parameter int WF_ID_W      = DEF_WF_ID_W,
    parameter int NUM_SIMD     = DEF_NUM_SIMD,
    parameter int NUM_SIMF     = DEF_NUM_SIMF,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_WF-1:0]   salu_ready_to_issue,
    input  logic [NUM_WF-1:0]   simd_ready_to_issue,
    input  logic [NUM_WF-1:0]   simf_ready_to_issue,
    input  logic [NUM_WF-1:0]   lsu_ready_to_issue,
    input  logic [NUM_SIMD-1:0] simd_alu_ready,
    input  logic [NUM_SIMF-1:0] simf_alu_ready,
    input  logic                salu_alu_ready,
    input  logic                lsu_ready,
    output logic [NUM_SIMD-1:0] simd_alu_select,
    output logic [NUM_SIMF-1:0] simf_alu_select,
    output logic                salu_alu_select,
    output logic                lsu_lsu_select,
    output logic [WF_ID_W-1:0]  issued_wfid,
    output logic [WF_ID_W-1:0]  alu_wfid,
    output logic [WF_ID_W-1:0]  lsu_wfid,
    output logic                issued_valid,
    output logic                alu_valid,
    output logic                lsu_valid
);

    if (NUM_WF > (1 << WF_ID_W) || NUM_SIMD < 1 || NUM_SIMD > 8 ||
        NUM_SIMF < 1 || NUM_SIMF > 8 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_param_check
        $error("issue_arbiter_gen: parameter out of range");
    end

    // Stage 1: registered inputs
    logic [NUM_WF-1:0]   rdy_q [NUM_CLS];
    logic [NUM_SIMD-1:0] simd_rdy_q;
    logic [NUM_SIMF-1:0] simf_rdy_q;
    logic                salu_rdy_q, lsu_rdy_q;

    // Stage 2: current issue (the outputs) and the issue one cycle before
    logic [NUM_SIMD-1:0] simd_sel_q, simd_sel_d, simd_sel_prev_q;
    logic [NUM_SIMF-1:0] simf_sel_q, simf_sel_d, simf_sel_prev_q;
    logic                salu_sel_q, salu_sel_d, salu_sel_prev_q;
    logic                lsu_sel_q, lsu_sel_d, lsu_sel_prev_q;
    logic [WF_ID_W-1:0]  wfid_q, wfid_d, prev_wfid_q;
    logic                valid_q, valid_d, prev_valid_q;

    // Search pointers
    logic [WF_ID_W-1:0]  wf_ptr_q [NUM_CLS];
    logic [WF_ID_W-1:0]  wf_ptr_d;
    logic [WF_ID_W:0]    ptr_inc;
    cls_e                cls_ptr_q, cls_ptr_d;

    // Arbitration
    logic [NUM_WF-1:0]   wf_block;
    logic [NUM_WF-1:0]   masked [NUM_CLS];
    logic [NUM_CLS-1:0]  found, elig;
    logic [WF_ID_W-1:0]  cand_id [NUM_CLS];
    logic [NUM_SIMD-1:0] simd_free, simd_pick;
    logic [NUM_SIMF-1:0] simf_free, simf_pick;
    logic                salu_free, lsu_free;
    cls_e                win, rot_cls;
    logic                any;

    // A wavefront issued this cycle or last cycle is still in flight and
    // the upstream ready vectors may not reflect it yet, so hide it.
    always_comb begin
        wf_block = '0;
        for (int w = 0; w < NUM_WF; w++) begin
            wf_block[w] = (valid_q && wfid_q == WF_ID_W'(w)) ||
                          (prev_valid_q && prev_wfid_q == WF_ID_W'(w));
        end
    end

    for (genvar c = 0; c < NUM_CLS; c++) begin : g_rr
        assign masked[c] = rdy_q[c] & ~wf_block;
        rr_arbiter #(.NUM_WF(NUM_WF), .WF_ID_W(WF_ID_W)) u_rr (
            .vec_i   (masked[c]),
            .ptr_i   (wf_ptr_q[c]),
            .valid_o (found[c]),
            .id_o    (cand_id[c])
        );
    end

    // Units selected this cycle or last cycle are treated as busy.
    assign simd_free = simd_rdy_q & ~(simd_sel_q | simd_sel_prev_q);
    assign simf_free = simf_rdy_q & ~(simf_sel_q | simf_sel_prev_q);
    assign salu_free = salu_rdy_q & ~(salu_sel_q | salu_sel_prev_q);
    assign lsu_free  = lsu_rdy_q  & ~(lsu_sel_q  | lsu_sel_prev_q);
    // x & -x isolates the lowest set bit.
    assign simd_pick = simd_free & (-simd_free);
    assign simf_pick = simf_free & (-simf_free);

    assign elig[CLS_SALU] = found[CLS_SALU] & salu_free;
    assign elig[CLS_SIMD] = found[CLS_SIMD] & (|simd_free);
    assign elig[CLS_SIMF] = found[CLS_SIMF] & (|simf_free);
    assign elig[CLS_LSU]  = found[CLS_LSU]  & lsu_free;

`ifdef ISSUE_STARVATION_GUARD_EN
    logic [STARVE_CNT_W-1:0] starve_cnt_q [NUM_CLS];
    logic [STARVE_CNT_W-1:0] starve_cnt_d [NUM_CLS];
    logic [NUM_CLS-1:0]      starved;

    always_comb begin
        for (int c = 0; c < NUM_CLS; c++) begin
            starved[c]      = elig[c] && (starve_cnt_q[c] >= STARVE_CNT_W'(STARVE_LIMIT));
            starve_cnt_d[c] = starve_cnt_q[c];
            if (any && win == cls_e'(2'(c))) begin
                starve_cnt_d[c] = '0;
            end else if (elig[c] && starve_cnt_q[c] != '1) begin
                starve_cnt_d[c] = starve_cnt_q[c] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CLS; c++) starve_cnt_q[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CLS; c++) starve_cnt_q[c] <= starve_cnt_d[c];
        end
    end
`endif

    // Winner: rotating priority from cls_ptr_q; a starved class (when the
    // guard is built in) overrides it, lowest class index first.
    always_comb begin
        win     = cls_ptr_q;
        rot_cls = cls_ptr_q;
        any     = 1'b0;
        for (int k = NUM_CLS - 1; k >= 0; k--) begin
            rot_cls = cls_e'(cls_ptr_q + 2'(k));
            if (elig[rot_cls]) begin
                win = rot_cls;
                any = 1'b1;
            end
        end
`ifdef ISSUE_STARVATION_GUARD_EN
        for (int c = NUM_CLS - 1; c >= 0; c--) begin
            if (starved[c]) begin
                win = cls_e'(2'(c));
                any = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        simd_sel_d = '0;
        simf_sel_d = '0;
        salu_sel_d = 1'b0;
        lsu_sel_d  = 1'b0;
        valid_d    = any;
        wfid_d     = wfid_q;
        cls_ptr_d  = cls_ptr_q;
        ptr_inc    = {1'b0, cand_id[win]} + (WF_ID_W + 1)'(1);
        wf_ptr_d   = (ptr_inc == (WF_ID_W + 1)'(NUM_WF)) ? '0 : ptr_inc[WF_ID_W-1:0];
        if (any) begin
            wfid_d    = cand_id[win];
            cls_ptr_d = next_cls(win);
            unique case (win)
                CLS_SALU: salu_sel_d = 1'b1;
                CLS_SIMD: simd_sel_d = simd_pick;
                CLS_SIMF: simf_sel_d = simf_pick;
                CLS_LSU:  lsu_sel_d  = 1'b1;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CLS; c++) begin
                rdy_q[c]    <= '0;
                wf_ptr_q[c] <= '0;
            end
            simd_rdy_q      <= '0;
            simf_rdy_q      <= '0;
            salu_rdy_q      <= 1'b0;
            lsu_rdy_q       <= 1'b0;
            simd_sel_q      <= '0;
            simf_sel_q      <= '0;
            salu_sel_q      <= 1'b0;
            lsu_sel_q       <= 1'b0;
            simd_sel_prev_q <= '0;
            simf_sel_prev_q <= '0;
            salu_sel_prev_q <= 1'b0;
            lsu_sel_prev_q  <= 1'b0;
            wfid_q          <= '0;
            prev_wfid_q     <= '0;
            valid_q         <= 1'b0;
            prev_valid_q    <= 1'b0;
            cls_ptr_q       <= CLS_SALU;
        end else begin
            rdy_q[CLS_SALU] <= salu_ready_to_issue;
            rdy_q[CLS_SIMD] <= simd_ready_to_issue;
            rdy_q[CLS_SIMF] <= simf_ready_to_issue;
            rdy_q[CLS_LSU]  <= lsu_ready_to_issue;
            simd_rdy_q      <= simd_alu_ready;
            simf_rdy_q      <= simf_alu_ready;
            salu_rdy_q      <= salu_alu_ready;
            lsu_rdy_q       <= lsu_ready;
            simd_sel_prev_q <= simd_sel_q;
            simf_sel_prev_q <= simf_sel_q;
            salu_sel_prev_q <= salu_sel_q;
            lsu_sel_prev_q  <= lsu_sel_q;
            prev_wfid_q     <= wfid_q;
            prev_valid_q    <= valid_q;
            simd_sel_q      <= simd_sel_d;
            simf_sel_q      <= simf_sel_d;
            salu_sel_q      <= salu_sel_d;
            lsu_sel_q       <= lsu_sel_d;
            wfid_q          <= wfid_d;
            valid_q         <= valid_d;
            cls_ptr_q       <= cls_ptr_d;
            if (valid_d) begin
                for (int c = 0; c < NUM_CLS; c++) wf_ptr_q[c] <= wf_ptr_d;
            end
        end
    end

    assign simd_alu_select = simd_sel_q;
    assign simf_alu_select = simf_sel_q;
    assign salu_alu_select = salu_sel_q;
    assign lsu_lsu_select  = lsu_sel_q;
    assign issued_wfid     = wfid_q;
    assign alu_wfid        = wfid_q;
    assign lsu_wfid        = wfid_q;
    assign issued_valid    = valid_q;
    assign alu_valid       = (|simd_sel_q) | (|simf_sel_q) | salu_sel_q;
    assign lsu_valid       = lsu_sel_q;

endmodule

// File: tb/tb_issue_arbiter_gen.sv
// -----------------------------------------------------------------------------
// tb_issue_arbiter_gen
// Directed scenarios plus randomized traffic for issue_arbiter_gen, compared
// each cycle against a behavioural model that tracks the last two issues as
// (class, wavefront, unit) records. Honours ISSUE_STARVATION_GUARD_EN.
// -----------------------------------------------------------------------------
module tb_issue_arbiter_gen;

    localparam int NUM_WF   = 40;
    localparam int WF_ID_W  = 6;
    localparam int NUM_SIMD = 4;
    localparam int NUM_SIMF = 4;
`ifdef ISSUE_STARVATION_GUARD_EN
    localparam int STARVE_LIMIT = 2;
    localparam bit GUARD        = 1'b1;
`else
    localparam int STARVE_LIMIT = 8;
    localparam bit GUARD        = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [NUM_WF-1:0]   salu_rdy, simd_rdy, simf_rdy, lsu_rdy;
    logic [NUM_SIMD-1:0] simd_alu_ready;
    logic [NUM_SIMF-1:0] simf_alu_ready;
    logic                salu_alu_ready, lsu_ready;
    logic [NUM_SIMD-1:0] simd_alu_select;
    logic [NUM_SIMF-1:0] simf_alu_select;
    logic                salu_alu_select, lsu_lsu_select;
    logic [WF_ID_W-1:0]  issued_wfid, alu_wfid, lsu_wfid;
    logic                issued_valid, alu_valid, lsu_valid;

    always #5 clk = ~clk;

    issue_arbiter_gen #(
        .NUM_WF(NUM_WF), .WF_ID_W(WF_ID_W), .NUM_SIMD(NUM_SIMD),
        .NUM_SIMF(NUM_SIMF), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .salu_ready_to_issue(salu_rdy), .simd_ready_to_issue(simd_rdy),
        .simf_ready_to_issue(simf_rdy), .lsu_ready_to_issue(lsu_rdy),
        .simd_alu_ready(simd_alu_ready), .simf_alu_ready(simf_alu_ready),
        .salu_alu_ready(salu_alu_ready), .lsu_ready(lsu_ready),
        .simd_alu_select(simd_alu_select), .simf_alu_select(simf_alu_select),
        .salu_alu_select(salu_alu_select), .lsu_lsu_select(lsu_lsu_select),
        .issued_wfid(issued_wfid), .alu_wfid(alu_wfid), .lsu_wfid(lsu_wfid),
        .issued_valid(issued_valid), .alu_valid(alu_valid), .lsu_valid(lsu_valid)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [NUM_WF-1:0]   m_rdy [4];
    logic [NUM_SIMD-1:0] m_simd_u;
    logic [NUM_SIMF-1:0] m_simf_u;
    logic                m_salu_u, m_lsu_u;
    int cur_cls, cur_wf, cur_unit, last_cls, last_wf, last_unit;
    int m_ptr, m_cptr, m_wfid;
    int m_cnt [4];

    function automatic bit wf_busy(input int w);
        return (cur_cls >= 0 && cur_wf == w) || (last_cls >= 0 && last_wf == w);
    endfunction

    function automatic bit unit_busy(input int c, input int u);
        return (cur_cls == c && cur_unit == u) || (last_cls == c && last_unit == u);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_rdy[c] = '0;
            m_cnt[c] = 0;
        end
        m_simd_u = '0; m_simf_u = '0; m_salu_u = 1'b0; m_lsu_u = 1'b0;
        cur_cls = -1; cur_wf = 0; cur_unit = 0;
        last_cls = -1; last_wf = 0; last_unit = 0;
        m_ptr = 0; m_cptr = 0; m_wfid = 0;
    endtask

    task automatic model_step();
        int fw [4];
        int fu [4];
        bit el [4];
        int winner;
        for (int c = 0; c < 4; c++) begin
            fw[c] = -1;
            for (int k = 0; k < NUM_WF; k++) begin
                if (fw[c] < 0 && m_rdy[c][(m_ptr + k) % NUM_WF] && !wf_busy((m_ptr + k) % NUM_WF))
                    fw[c] = (m_ptr + k) % NUM_WF;
            end
        end
        fu[0] = (m_salu_u && !unit_busy(0, 0)) ? 0 : -1;
        fu[3] = (m_lsu_u && !unit_busy(3, 0)) ? 0 : -1;
        fu[1] = -1;
        for (int u = 0; u < NUM_SIMD; u++)
            if (fu[1] < 0 && m_simd_u[u] && !unit_busy(1, u)) fu[1] = u;
        fu[2] = -1;
        for (int u = 0; u < NUM_SIMF; u++)
            if (fu[2] < 0 && m_simf_u[u] && !unit_busy(2, u)) fu[2] = u;
        for (int c = 0; c < 4; c++) el[c] = (fw[c] >= 0) && (fu[c] >= 0);

        winner = -1;
        if (GUARD)
            for (int c = 0; c < 4; c++)
                if (winner < 0 && el[c] && m_cnt[c] >= STARVE_LIMIT) winner = c;
        if (winner < 0)
            for (int k = 0; k < 4; k++)
                if (winner < 0 && el[(m_cptr + k) % 4]) winner = (m_cptr + k) % 4;
        if (GUARD)
            for (int c = 0; c < 4; c++) begin
                if (c == winner) m_cnt[c] = 0;
                else if (el[c] && m_cnt[c] < 15) m_cnt[c] = m_cnt[c] + 1;
            end

        last_cls = cur_cls; last_wf = cur_wf; last_unit = cur_unit;
        if (winner >= 0) begin
            cur_cls = winner; cur_wf = fw[winner]; cur_unit = fu[winner];
            m_wfid = fw[winner];
            m_ptr  = (fw[winner] + 1) % NUM_WF;
            m_cptr = (winner + 1) % 4;
        end else begin
            cur_cls = -1;
        end

        m_rdy[0] = salu_rdy; m_rdy[1] = simd_rdy; m_rdy[2] = simf_rdy; m_rdy[3] = lsu_rdy;
        m_simd_u = simd_alu_ready; m_simf_u = simf_alu_ready;
        m_salu_u = salu_alu_ready; m_lsu_u = lsu_ready;
    endtask

    task automatic compare_all();
        check("salu_sel", salu_alu_select, 64'(cur_cls == 0));
        check("simd_sel", simd_alu_select, (cur_cls == 1) ? (64'd1 << cur_unit) : 64'd0);
        check("simf_sel", simf_alu_select, (cur_cls == 2) ? (64'd1 << cur_unit) : 64'd0);
        check("lsu_sel", lsu_lsu_select, 64'(cur_cls == 3));
        check("issued_valid", issued_valid, 64'(cur_cls >= 0));
        check("alu_valid", alu_valid, 64'(cur_cls >= 0 && cur_cls <= 2));
        check("lsu_valid", lsu_valid, 64'(cur_cls == 3));
        check("issued_wfid", issued_wfid, 64'(m_wfid));
        check("alu_wfid", alu_wfid, 64'(m_wfid));
        check("lsu_wfid", lsu_wfid, 64'(m_wfid));
    endtask

    // One rising edge: advance the model with the inputs held across it.
    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        compare_all();
    endtask

    task automatic clear_inputs();
        salu_rdy = '0; simd_rdy = '0; simf_rdy = '0; lsu_rdy = '0;
        simd_alu_ready = '0; simf_alu_ready = '0;
        salu_alu_ready = 1'b0; lsu_ready = 1'b0;
    endtask

    task automatic check_zero(input string p);
        check({p, "_salu_sel"}, salu_alu_select, 0);
        check({p, "_simd_sel"}, simd_alu_select, 0);
        check({p, "_simf_sel"}, simf_alu_select, 0);
        check({p, "_lsu_sel"}, lsu_lsu_select, 0);
        check({p, "_wfid"}, issued_wfid, 0);
        check({p, "_valid"}, issued_valid, 0);
        check({p, "_alu_valid"}, alu_valid, 0);
        check({p, "_lsu_valid"}, lsu_valid, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [NUM_WF-1:0] rand_vec(input int density);
        logic [NUM_WF-1:0] v;
        for (int i = 0; i < NUM_WF; i++) v[i] = ($urandom_range(0, density - 1) == 0);
        return v;
    endfunction

    task automatic randomize_inputs(input int density);
        salu_rdy = rand_vec(density);
        simd_rdy = rand_vec(density);
        simf_rdy = rand_vec(density);
        lsu_rdy  = rand_vec(density);
        simd_alu_ready = NUM_SIMD'($urandom);
        simf_alu_ready = NUM_SIMF'($urandom);
        salu_alu_ready = ($urandom_range(0, 3) != 0);
        lsu_ready      = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        int n7;
        int consec;
        int lsu_lat;
        bit prev7;

        rst = 1'b0;
        clear_inputs();
        #2;
        do_reset();

        // Single SALU wavefront: two-edge latency, no back-to-back reissue.
        salu_rdy[5] = 1'b1;
        salu_alu_ready = 1'b1;
        tick();
        check("r028_edge1_valid", issued_valid, 0);
        tick();
        check("r028_salu_sel", salu_alu_select, 1);
        check("r028_wfid", issued_wfid, 5);
        check("r028_alu_valid", alu_valid, 1);
        tick();
        check("r028_no_reissue", issued_valid, 0);

        // SIMD round robin over wfs 3 and 39 with wrap.
        do_reset();
        simd_rdy[3] = 1'b1;
        simd_rdy[39] = 1'b1;
        simd_alu_ready = 4'hF;
        tick();
        tick();
        check("r029_first_wfid", issued_wfid, 3);
        check("r029_first_sel", simd_alu_select, 4'b0001);
        tick();
        check("r029_second_wfid", issued_wfid, 39);
        check("r029_second_sel", simd_alu_select, 4'b0010);
        tick();
        check("r029_gap_valid", issued_valid, 0);
        tick();
        check("r029_wrap_wfid", issued_wfid, 3);
        check("r029_wrap_valid", issued_valid, 1);

        // Class rotation SALU, SIMD, SIMF, LSU.
        do_reset();
        salu_rdy[1] = 1'b1; simd_rdy[2] = 1'b1; simf_rdy[3] = 1'b1; lsu_rdy[4] = 1'b1;
        simd_alu_ready = '1; simf_alu_ready = '1; salu_alu_ready = 1'b1; lsu_ready = 1'b1;
        tick();
        tick();
        check("r030_salu", salu_alu_select, 1);
        check("r030_salu_wfid", issued_wfid, 1);
        tick();
        check("r030_simd", simd_alu_select, 1);
        check("r030_simd_wfid", issued_wfid, 2);
        tick();
        check("r030_simf", simf_alu_select, 1);
        check("r030_simf_wfid", issued_wfid, 3);
        tick();
        check("r030_lsu", lsu_lsu_select, 1);
        check("r030_lsu_wfid", issued_wfid, 4);

        // Same wavefront in SALU and LSU for one input cycle.
        do_reset();
        salu_alu_ready = 1'b1; lsu_ready = 1'b1;
        salu_rdy[7] = 1'b1; lsu_rdy[7] = 1'b1;
        tick();
        salu_rdy = '0; lsu_rdy = '0;
        n7 = 0; consec = 0; prev7 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (issued_valid && issued_wfid == 7) begin
                n7++;
                if (prev7) consec++;
            end
            prev7 = issued_valid && issued_wfid == 7;
        end
        check("r031_issue_count", n7, 1);
        check("r031_consecutive", consec, 0);

        // LSU latency while the other classes keep competing.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            salu_rdy[i] = 1'b1; simd_rdy[10 + i] = 1'b1;
            simf_rdy[20 + i] = 1'b1; lsu_rdy[30 + i] = 1'b1;
        end
        simd_alu_ready = '1; simf_alu_ready = '1; salu_alu_ready = 1'b1; lsu_ready = 1'b1;
        tick();
        lsu_lat = -1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (lsu_lat < 0 && lsu_valid) lsu_lat = i;
        end
        check("r032_lsu_within_3", 64'(lsu_lat >= 0 && lsu_lat <= 3), 1);

        // Randomized traffic with an asynchronous reset in the middle.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            randomize_inputs((cyc < 1500) ? 6 : 2);
            tick();
            if (cyc == 1200) begin
                #2;
                rst = 1'b0;
                #1;
                check_zero("async_rst");
                clear_inputs();
                salu_rdy[5] = 1'b1;
                salu_alu_ready = 1'b1;
                model_reset();
                @(negedge clk);
                rst = 1'b1;
                tick();
                check("r033_edge1_valid", issued_valid, 0);
                tick();
                check("r033_edge2_valid", issued_valid, 1);
                check("r033_edge2_wfid", issued_wfid, 5);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
